mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Parametrised, sequential load/store controller in the MEM stage. Per-access byte-lane selection, write-data replication, alignment exceptions and load sign/zero extension, generalised to a 32- or 64-bit data bus. Drives the data-side SRAM-like handshake (req/addr_ok/data_ok) and stalls the pipeline until the access completes. Flushed accesses are drained on the bus and their results discarded.

## Interface
- BUS_W, 32: data bus width; 32 or 64. LANES = BUS_W/8, OFS_W = log2(LANES).
- ADDR_W, 32: address width.

- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  MEM stage holds a memory instruction
- memwrite  in  1  1 = store, 0 = load
- memop  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
- addr  in  ADDR_W  effective address
- pc  in  32  instruction PC
- wdata  in  32  store data (rt)
- flush  in  1  exception flush of MEM stage
- stall  out  1  hold pipeline
- resp_valid  out  1  load/store completed this cycle
- ldata  out  32  extended load result, valid with resp_valid on loads
- adel / ades  out  1  load / store address error
- bad_addr  out  32  faulting address
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  ADDR_W  request address (unaligned low bits passed through)
- data_wstrb  out  LANES  byte enables
- data_wdata  out  BUS_W  replicated store data
- data_addr_ok  in  1  address accepted
- data_data_ok  in  1  data returned / write done
- data_rdata  in  BUS_W  read data

## Operation
- Legal op: load with memop 000–100, or store with memop 101–111. Any other combination is a no-op: no transaction, no exception, stall=0.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0. Byte accesses are always aligned.
- Misaligned legal op in IDLE with !flush: adel (load) or ades (store) asserted combinationally that cycle, bad_addr=addr, no bus request, stall=0. Otherwise adel=ades=0 and bad_addr=pc.
- ofs = addr[OFS_W-1:0].
- Store strobes: byte sets 1 bit at lane ofs; half sets 2 bits at ofs; word sets 4 bits at ofs. wdata is replicated: byte LANES times, half LANES/2 times, word BUS_W/32 times.
- Load extract: data_rdata >> (8*ofs). Take the low 8, 16 or 32 bits. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE: on an aligned legal op with req_valid & !flush, register addr/size/wr/wstrb/wdata/memop, go to ADDR. stall=1 combinationally in this cycle.
  - ADDR: data_req=1, registered fields are held stable. On addr_ok go to DATA. If data_ok arrives in the same cycle, treat it as DATA completion.
  - DATA: data_req=0. On data_ok, capture ldata (loads) and go to DONE. If cancel is set, go to IDLE instead.
  - DONE: stall=0, resp_valid=1 for one cycle, then go to IDLE. The held instruction retires on this edge; IDLE never re-issues it.
- cancel flag: set by flush in ADDR or DATA. The bus transaction still completes (data_req held until addr_ok). No resp_valid, ldata is not updated, and cancel clears on return to IDLE.
- stall=1 in ADDR and DATA, including while cancelled.

## Timing
- Reset (async): state IDLE, cancel 0. Registered data_req/data_wr/data_size/data_addr/data_wstrb/data_wdata all 0. ldata 0, resp_valid 0.
- Best-case latency: IDLE → ADDR → DATA → DONE, with addr_ok and data_ok each in their first possible cycle. That is 3 stall cycles plus the DONE cycle.
- If addr_ok and data_ok arrive in the same ADDR cycle, go to DONE next: 2 stall cycles.
- data_req, data_addr and data_wstrb are registered outputs and do not change while in ADDR.
- flush in IDLE: nothing is issued and no exception is raised.
- flush in the DONE cycle: resp_valid is still asserted; the pipeline discards it.
- rst mid-transaction aborts immediately. The bus slave is reset by the same rst.

## Test plan
- BUS_W=32, SB addr=0x1003, wdata=0x000000AB, zero-wait bus → data_wstrb=1000, data_wdata=0xABABABAB, data_size=0, resp_valid one cycle after data_ok.
- BUS_W=32, LH addr=0x2002, rdata=0x8001_0000 → ldata=0xFFFF8001. LHU with the same inputs → ldata=0x00008001.
- BUS_W=64, LW addr=0x3004, rdata=0x12345678_9ABCDEF0 → ldata=0x12345678, data_wstrb unused, stall held 3 cycles.
- SW addr=0x4002 → ades=1, bad_addr=0x4002, data_req never rises, stall=0. LW addr=0x4001 → adel=1, bad_addr=0x4001.
- LW issued, addr_ok delayed 4 cycles, flush in cycle 2 → data_req held until addr_ok, data_ok consumed, no resp_valid, ldata unchanged, back to IDLE.
- Assert rst while in DATA → all outputs 0 immediately; next aligned op after rst release completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store controller driving an SRAM-like req/addr_ok/data_ok data bus.
// Latency: best case 3 stall cycles then 1 response cycle; 2 stall cycles when addr_ok and data_ok coincide.
// Backpressure: o_stall holds the pipeline while the bus access is outstanding; flushed accesses drain silently.
module mem_access_ctrl #(
  parameter int BUS_W  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  input  logic                 i_memwrite,
  input  logic [2:0]           i_memop,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [31:0]          i_pc,
  input  logic [31:0]          i_wdata,
  input  logic                 i_flush,
  output logic                 o_stall,
  output logic                 o_resp_valid,
  output logic [31:0]          o_ldata,
  output logic                 o_adel,
  output logic                 o_ades,
  output logic [31:0]          o_bad_addr,
  output logic                 o_data_req,
  output logic                 o_data_wr,
  output logic [1:0]           o_data_size,
  output logic [ADDR_W-1:0]    o_data_addr,
  output logic [BUS_W/8-1:0]   o_data_wstrb,
  output logic [BUS_W-1:0]     o_data_wdata,
  input  logic                 i_data_addr_ok,
  input  logic                 i_data_data_ok,
  input  logic [BUS_W-1:0]     i_data_rdata
);
  localparam int LANES = BUS_W / 8;
  localparam int OFS_W = $clog2(LANES);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_cancel;
  logic                r_data_req;
  logic                r_data_wr;
  logic [1:0]          r_data_size;
  logic [ADDR_W-1:0]   r_data_addr;
  logic [LANES-1:0]    r_data_wstrb;
  logic [BUS_W-1:0]    r_data_wdata;
  logic [2:0]          r_memop;
  logic [31:0]         r_ldata;

  logic                w_legal;
  logic                w_misal;
  logic                w_issue;
  logic                w_exc;
  logic                w_cancel;
  logic                w_fin;
  logic [1:0]          w_size;
  logic [OFS_W-1:0]    w_ofs;
  logic [LANES-1:0]    w_wstrb;
  logic [BUS_W-1:0]    w_wdata;
  logic [31:0]         w_lane;
  logic [31:0]         w_ext;
  logic [31:0]         w_addr32;

  assign w_ofs    = i_addr[OFS_W-1:0];
  assign w_addr32 = 32'(i_addr);

  // Decode the incoming access: legality, size, alignment, byte lanes and replicated store data
  always_comb begin
    w_legal = i_memwrite ? (i_memop >= 3'd5) : (i_memop <= 3'd4);
    case (i_memop)
      3'd0, 3'd1, 3'd5: w_size = 2'd0;
      3'd2, 3'd3, 3'd6: w_size = 2'd1;
      default:          w_size = 2'd2;
    endcase
    w_misal = ((w_size == 2'd1) && i_addr[0]) || ((w_size == 2'd2) && (i_addr[1:0] != 2'b00));
    w_wstrb = '0;
    w_wdata = {(BUS_W/32){i_wdata}};
    if (i_memwrite) begin
      case (w_size)
        2'd0: begin
          w_wstrb = LANES'(1) << w_ofs;
          w_wdata = {LANES{i_wdata[7:0]}};
        end
        2'd1: begin
          w_wstrb = LANES'(3) << w_ofs;
          w_wdata = {(LANES/2){i_wdata[15:0]}};
        end
        default: w_wstrb = LANES'(15) << w_ofs;
      endcase
    end
  end

  // Qualify the request: issue an aligned access, or flag a misaligned one; flush in ADDR/DATA cancels at once
  always_comb begin
    w_issue  = (r_state == S_IDLE) && i_req_valid && !i_flush && w_legal && !w_misal;
    w_exc    = (r_state == S_IDLE) && i_req_valid && !i_flush && w_legal && w_misal && !i_rst;
    w_cancel = r_cancel || i_flush;
    w_fin    = ((r_state == S_ADDR) && i_data_addr_ok && i_data_data_ok) ||
               ((r_state == S_DATA) && i_data_data_ok);
  end

  // Select the addressed lanes of the returned word and extend to 32 bits
  always_comb begin
    w_lane = 32'(i_data_rdata >> {r_data_addr[OFS_W-1:0], 3'b000});
    case (r_memop)
      3'd0:    w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'd1:    w_ext = {24'd0, w_lane[7:0]};
      3'd2:    w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'd3:    w_ext = {16'd0, w_lane[15:0]};
      default: w_ext = w_lane;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: a cancelled access drains its bus transaction, then returns straight to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_issue) w_next = S_ADDR;
      S_ADDR: if (i_data_addr_ok) begin
        if (i_data_data_ok) w_next = w_cancel ? S_IDLE : S_DONE;
        else                w_next = S_DATA;
      end
      S_DATA: if (i_data_data_ok) w_next = w_cancel ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic: stall from issue until completion, exceptions only from IDLE
  always_comb begin
    o_stall      = !i_rst && (w_issue || (r_state == S_ADDR) || (r_state == S_DATA));
    o_adel       = w_exc && !i_memwrite;
    o_ades       = w_exc && i_memwrite;
    o_bad_addr   = w_exc ? w_addr32 : i_pc;
    o_resp_valid = (r_state == S_DONE);
  end

  // Bus request fields: captured on issue, held through ADDR, request dropped once the address is taken
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_req   <= 1'b0;
      r_data_wr    <= 1'b0;
      r_data_size  <= 2'd0;
      r_data_addr  <= '0;
      r_data_wstrb <= '0;
      r_data_wdata <= '0;
      r_memop      <= 3'd0;
    end else if (w_issue) begin
      r_data_req   <= 1'b1;
      r_data_wr    <= i_memwrite;
      r_data_size  <= w_size;
      r_data_addr  <= i_addr;
      r_data_wstrb <= w_wstrb;
      r_data_wdata <= w_wdata;
      r_memop      <= i_memop;
    end else if ((r_state == S_ADDR) && i_data_addr_ok) begin
      r_data_req   <= 1'b0;
    end
  end

  // Cancel flag: remembers a flush seen mid-transaction, cleared on the way back to IDLE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                                          r_cancel <= 1'b0;
    else if (w_next == S_IDLE)                                          r_cancel <= 1'b0;
    else if (((r_state == S_ADDR) || (r_state == S_DATA)) && i_flush)   r_cancel <= 1'b1;
  end

  // Load result: updated only by a completed, non-cancelled load
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                r_ldata <= 32'd0;
    else if (w_fin && !w_cancel && !r_data_wr) r_ldata <= w_ext;
  end

  assign o_ldata      = r_ldata;
  assign o_data_req   = r_data_req;
  assign o_data_wr    = r_data_wr;
  assign o_data_size  = r_data_size;
  assign o_data_addr  = r_data_addr;
  assign o_data_wstrb = r_data_wstrb;
  assign o_data_wdata = r_data_wdata;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: drives 32- and 64-bit instances in lockstep from one bus-slave script.
// Expected values come from hand tables and a transaction-level byte-lane model.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, memwrite, flush, addr_ok, data_ok;
  logic [2:0]  memop;
  logic [31:0] addr, pc, wdata;
  logic [63:0] rdata64;

  logic        s32_stall, s32_resp, s32_adel, s32_ades, s32_req, s32_wr;
  logic [31:0] s32_bad, s32_ldata, s32_daddr, s32_wdata;
  logic [1:0]  s32_size;
  logic [3:0]  s32_wstrb;
  logic        s64_stall, s64_resp, s64_adel, s64_ades, s64_req, s64_wr;
  logic [31:0] s64_bad, s64_ldata, s64_daddr;
  logic [63:0] s64_wdata;
  logic [1:0]  s64_size;
  logic [7:0]  s64_wstrb;

  mem_access_ctrl #(.BUS_W(32), .ADDR_W(32)) u32 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_memwrite(memwrite), .i_memop(memop),
    .i_addr(addr), .i_pc(pc), .i_wdata(wdata), .i_flush(flush), .o_stall(s32_stall),
    .o_resp_valid(s32_resp), .o_ldata(s32_ldata), .o_adel(s32_adel), .o_ades(s32_ades),
    .o_bad_addr(s32_bad), .o_data_req(s32_req), .o_data_wr(s32_wr), .o_data_size(s32_size),
    .o_data_addr(s32_daddr), .o_data_wstrb(s32_wstrb), .o_data_wdata(s32_wdata),
    .i_data_addr_ok(addr_ok), .i_data_data_ok(data_ok), .i_data_rdata(rdata64[31:0]));

  mem_access_ctrl #(.BUS_W(64), .ADDR_W(32)) u64 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_memwrite(memwrite), .i_memop(memop),
    .i_addr(addr), .i_pc(pc), .i_wdata(wdata), .i_flush(flush), .o_stall(s64_stall),
    .o_resp_valid(s64_resp), .o_ldata(s64_ldata), .o_adel(s64_adel), .o_ades(s64_ades),
    .o_bad_addr(s64_bad), .o_data_req(s64_req), .o_data_wr(s64_wr), .o_data_size(s64_size),
    .o_data_addr(s64_daddr), .o_data_wstrb(s64_wstrb), .o_data_wdata(s64_wdata),
    .i_data_addr_ok(addr_ok), .i_data_data_ok(data_ok), .i_data_rdata(rdata64));

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic logic [1:0] size_of(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1 || op == 3'd5) return 2'd0;
    if (op == 3'd2 || op == 3'd3 || op == 3'd6) return 2'd1;
    return 2'd2;
  endfunction

  function automatic int nbytes(input logic [2:0] op);
    return 1 << size_of(op);
  endfunction

  function automatic logic [7:0] m_strobe(input int lanes, input logic [31:0] a, input logic [2:0] op);
    logic [7:0] m = 8'd0;
    int o = int'(a % lanes);
    for (int i = 0; i < lanes; i++) if (i >= o && i < o + nbytes(op)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_wdata(input int lanes, input logic [31:0] wd, input logic [2:0] op);
    logic [63:0] m = 64'd0;
    for (int i = 0; i < lanes; i++) m[8*i +: 8] = wd[8*(i % nbytes(op)) +: 8];
    return m;
  endfunction

  function automatic logic [31:0] m_load(input int lanes, input logic [31:0] a, input logic [2:0] op,
                                         input logic [63:0] rd);
    logic [31:0] v = 32'd0;
    int o = int'(a % lanes);
    int n = nbytes(op);
    for (int j = 0; j < n; j++) v[8*j +: 8] = rd[8*(o+j) +: 8];
    if ((op == 3'd0 || op == 3'd2) && v[8*n-1]) for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- one transaction with a scripted bus slave ----------------
  // aw: idle ADDR cycles before addr_ok; dw: idle DATA cycles before data_ok (-1 = with addr_ok);
  // fl: cycle index of a flush pulse (0 = issue cycle), -1 for none.
  task automatic run_txn(input logic mw, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [63:0] rd, input int aw, input int dw, input int fl,
                         output int st32, output int st64, output int rv32, output int rv64,
                         output logic ok32, output logic ok64, output logic [3:0] ws32,
                         output logic [7:0] ws64, output logic [31:0] wd32, output logic [63:0] wd64);
    int   cyc = 0;
    logic gone = 1'b0;
    st32 = 0; st64 = 0; rv32 = 0; rv64 = 0; ok32 = 1'b1; ok64 = 1'b1;
    ws32 = '0; ws64 = '0; wd32 = '0; wd64 = '0;
    req_valid = 1'b1; memwrite = mw; memop = op; addr = a; wdata = wd; rdata64 = rd;
    flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    #1;
    st32 += int'(s32_stall); st64 += int'(s64_stall);
    tick(); cyc = 1;
    for (int k = 0; k <= aw; k++) begin
      addr_ok = (k == aw); data_ok = (k == aw) && (dw < 0);
      flush = (cyc == fl); gone = gone | flush; req_valid = !gone;
      #1;
      st32 += int'(s32_stall); st64 += int'(s64_stall);
      if (k == 0) begin ws32 = s32_wstrb; ws64 = s64_wstrb; wd32 = s32_wdata; wd64 = s64_wdata; end
      if (s32_req !== 1'b1 || s32_daddr !== a || s32_wr !== mw || s32_size !== size_of(op) ||
          s32_wstrb !== ws32) ok32 = 1'b0;
      if (s64_req !== 1'b1 || s64_daddr !== a || s64_wr !== mw || s64_size !== size_of(op) ||
          s64_wstrb !== ws64) ok64 = 1'b0;
      tick(); cyc++;
    end
    if (dw >= 0) begin
      for (int k = 0; k <= dw; k++) begin
        addr_ok = 1'b0; data_ok = (k == dw);
        flush = (cyc == fl); gone = gone | flush; req_valid = !gone;
        #1;
        st32 += int'(s32_stall); st64 += int'(s64_stall);
        if (s32_req !== 1'b0) ok32 = 1'b0;
        if (s64_req !== 1'b0) ok64 = 1'b0;
        tick(); cyc++;
      end
    end
    addr_ok = 1'b0; data_ok = 1'b0;
    flush = (cyc == fl); gone = gone | flush; req_valid = !gone;
    #1;
    st32 += int'(s32_stall); st64 += int'(s64_stall);
    rv32 += int'(s32_resp); rv64 += int'(s64_resp);
    tick();
    req_valid = 1'b0; flush = 1'b0;
    #1;
    st32 += int'(s32_stall); st64 += int'(s64_stall);
    rv32 += int'(s32_resp); rv64 += int'(s64_resp);
    tick();
  endtask

  typedef struct {
    logic mw; logic [2:0] op; logic [31:0] a; logic [31:0] wd; logic [63:0] rd;
    int aw; int dw; int fl; int st; int rv;
    logic [31:0] ld32; logic [31:0] ld64;
    logic [3:0] ws32; logic [7:0] ws64; logic [31:0] wd32; logic [63:0] wd64;
  } vec_t;

  task automatic do_vec(input string tag, input vec_t v);
    int st32, st64, rv32, rv64;
    logic ok32, ok64;
    logic [3:0] ws32; logic [7:0] ws64; logic [31:0] wd32; logic [63:0] wd64;
    run_txn(v.mw, v.op, v.a, v.wd, v.rd, v.aw, v.dw, v.fl,
            st32, st64, rv32, rv64, ok32, ok64, ws32, ws64, wd32, wd64);
    check({tag, " stall_cycles32"}, st32, v.st);
    check({tag, " stall_cycles64"}, st64, v.st);
    check({tag, " resp_count32"}, rv32, v.rv);
    check({tag, " resp_count64"}, rv64, v.rv);
    check({tag, " addr_phase32"}, ok32, 1);
    check({tag, " addr_phase64"}, ok64, 1);
    check({tag, " ldata32"}, s32_ldata, v.ld32);
    check({tag, " ldata64"}, s64_ldata, v.ld64);
    if (v.mw) begin
      check({tag, " wstrb32"}, ws32, v.ws32);
      check({tag, " wstrb64"}, ws64, v.ws64);
      check({tag, " wdata32"}, wd32, v.wd32);
      check({tag, " wdata64"}, wd64, v.wd64);
    end
  endtask

  function automatic vec_t mk(input logic mw, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] wd, input logic [63:0] rd, input int aw, input int dw,
                              input int fl, input int st, input int rv, input logic [31:0] ld32,
                              input logic [31:0] ld64, input logic [3:0] ws32, input logic [7:0] ws64,
                              input logic [31:0] wd32, input logic [63:0] wd64);
    vec_t v;
    v.mw = mw; v.op = op; v.a = a; v.wd = wd; v.rd = rd; v.aw = aw; v.dw = dw; v.fl = fl;
    v.st = st; v.rv = rv; v.ld32 = ld32; v.ld64 = ld64;
    v.ws32 = ws32; v.ws64 = ws64; v.wd32 = wd32; v.wd64 = wd64;
    return v;
  endfunction

  typedef struct {
    logic mw; logic [2:0] op; logic [31:0] a; logic fl; logic adel; logic ades; logic use_addr;
  } exc_t;

  vec_t vecs[$];
  exc_t excs[$];

  initial begin
    logic [31:0] prev32, prev64;
    vec_t v;
    exc_t e;

    rst = 1'b1; req_valid = 1'b0; memwrite = 1'b0; memop = 3'd0; addr = 32'd0; pc = 32'd0;
    wdata = 32'd0; flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata64 = 64'd0;

    // Directed transactions: {mw, op, addr, wdata, rdata, aw, dw, fl, stall, resp, ld32, ld64, strobes, wdata}
    vecs.push_back(mk(1, 3'd5, 32'h1003, 32'h000000AB, 64'h0, 0, 0, -1, 3, 1, 32'h0, 32'h0,
                      4'b1000, 8'h08, 32'hABABABAB, 64'hABABABAB_ABABABAB));
    vecs.push_back(mk(0, 3'd2, 32'h2002, 32'h0, 64'h00000000_80010000, 0, 0, -1, 3, 1,
                      32'hFFFF8001, 32'hFFFF8001, 4'h0, 8'h0, 32'h0, 64'h0));
    vecs.push_back(mk(0, 3'd3, 32'h2002, 32'h0, 64'h00000000_80010000, 0, 0, -1, 3, 1,
                      32'h00008001, 32'h00008001, 4'h0, 8'h0, 32'h0, 64'h0));
    vecs.push_back(mk(0, 3'd4, 32'h3004, 32'h0, 64'h12345678_9ABCDEF0, 0, 0, -1, 3, 1,
                      32'h9ABCDEF0, 32'h12345678, 4'h0, 8'h0, 32'h0, 64'h0));
    vecs.push_back(mk(0, 3'd0, 32'h2001, 32'h0, 64'h00000000_0000F200, 0, -1, -1, 2, 1,
                      32'hFFFFFFF2, 32'hFFFFFFF2, 4'h0, 8'h0, 32'h0, 64'h0));
    vecs.push_back(mk(0, 3'd1, 32'h2005, 32'h0, 64'h00007F00_00008000, 0, 0, -1, 3, 1,
                      32'h00000080, 32'h0000007F, 4'h0, 8'h0, 32'h0, 64'h0));
    vecs.push_back(mk(1, 3'd6, 32'h1006, 32'h1234CDEF, 64'h0, 2, 1, -1, 6, 1, 32'h00000080, 32'h0000007F,
                      4'b1100, 8'hC0, 32'hCDEFCDEF, 64'hCDEFCDEF_CDEFCDEF));
    vecs.push_back(mk(1, 3'd7, 32'h1000, 32'hDEADBEEF, 64'h0, 0, 2, -1, 5, 1, 32'h00000080, 32'h0000007F,
                      4'b1111, 8'h0F, 32'hDEADBEEF, 64'hDEADBEEF_DEADBEEF));
    vecs.push_back(mk(0, 3'd4, 32'h3000, 32'h0, 64'h11111111_22222222, 4, 0, 2, 7, 0,
                      32'h00000080, 32'h0000007F, 4'h0, 8'h0, 32'h0, 64'h0));
    vecs.push_back(mk(0, 3'd4, 32'h300C, 32'h0, 64'hAAAA5555_CAFEF00D, 1, 0, 4, 4, 1,
                      32'hCAFEF00D, 32'hAAAA5555, 4'h0, 8'h0, 32'h0, 64'h0));
    vecs.push_back(mk(1, 3'd5, 32'h1005, 32'h0000005A, 64'h0, 0, 0, 2, 3, 0, 32'hCAFEF00D, 32'hAAAA5555,
                      4'b0010, 8'h20, 32'h5A5A5A5A, 64'h5A5A5A5A_5A5A5A5A));

    // Single-cycle exception / no-op cases: {mw, op, addr, flush, adel, ades, bad_addr is addr}
    e = '{1'b1, 3'd7, 32'h4002, 1'b0, 1'b0, 1'b1, 1'b1}; excs.push_back(e);
    e = '{1'b0, 3'd4, 32'h4001, 1'b0, 1'b1, 1'b0, 1'b1}; excs.push_back(e);
    e = '{1'b0, 3'd2, 32'h4003, 1'b0, 1'b1, 1'b0, 1'b1}; excs.push_back(e);
    e = '{1'b1, 3'd6, 32'h4001, 1'b0, 1'b0, 1'b1, 1'b1}; excs.push_back(e);
    e = '{1'b1, 3'd0, 32'h4001, 1'b0, 1'b0, 1'b0, 1'b0}; excs.push_back(e);
    e = '{1'b0, 3'd6, 32'h4000, 1'b0, 1'b0, 1'b0, 1'b0}; excs.push_back(e);
    e = '{1'b0, 3'd4, 32'h4001, 1'b1, 1'b0, 1'b0, 1'b0}; excs.push_back(e);
    e = '{1'b0, 3'd4, 32'h4000, 1'b1, 1'b0, 1'b0, 1'b0}; excs.push_back(e);

    // Reset state
    tick(); tick();
    check("rst stall32", s32_stall, 0);      check("rst stall64", s64_stall, 0);
    check("rst data_req32", s32_req, 0);     check("rst data_req64", s64_req, 0);
    check("rst resp32", s32_resp, 0);        check("rst ldata32", s32_ldata, 0);
    check("rst wstrb64", s64_wstrb, 0);      check("rst wdata64", s64_wdata, 0);
    check("rst data_addr32", s32_daddr, 0);  check("rst size_wr32", {s32_size, s32_wr}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < vecs.size(); i++) do_vec($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < excs.size(); i++) begin
      e = excs[i];
      req_valid = 1'b1; memwrite = e.mw; memop = e.op; addr = e.a; flush = e.fl;
      pc = 32'h0000BEE0 + 32'(i);
      #1;
      check($sformatf("exc%0d adel", i), s32_adel, e.adel);
      check($sformatf("exc%0d ades", i), s32_ades, e.ades);
      check($sformatf("exc%0d bad_addr32", i), s32_bad, e.use_addr ? e.a : pc);
      check($sformatf("exc%0d bad_addr64", i), s64_bad, e.use_addr ? e.a : pc);
      check($sformatf("exc%0d stall32", i), s32_stall, 0);
      check($sformatf("exc%0d stall64", i), s64_stall, 0);
      tick();
      req_valid = 1'b0; flush = 1'b0;
      #1;
      check($sformatf("exc%0d no_req32", i), s32_req, 0);
      check($sformatf("exc%0d no_req64", i), s64_req, 0);
      tick();
    end

    // Reset while in DATA aborts at once; ldata currently holds a nonzero load result
    req_valid = 1'b1; memwrite = 1'b0; memop = 3'd4; addr = 32'h5004; rdata64 = 64'h0BADF00D_13572468;
    addr_ok = 1'b0; data_ok = 1'b0;
    tick();
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    #1;
    check("pre_rst stall32", s32_stall, 1);
    rst = 1'b1;
    #1;
    check("mid_rst stall32", s32_stall, 0);   check("mid_rst stall64", s64_stall, 0);
    check("mid_rst req32", s32_req, 0);       check("mid_rst resp32", s32_resp, 0);
    check("mid_rst ldata32", s32_ldata, 0);   check("mid_rst ldata64", s64_ldata, 0);
    check("mid_rst addr64", s64_daddr, 0);    check("mid_rst wdata32", s32_wdata, 0);
    tick();
    rst = 1'b0; req_valid = 1'b0;
    tick();
    v = mk(0, 3'd4, 32'h5004, 32'h0, 64'h0BADF00D_13572468, 0, 0, -1, 3, 1,
           32'h13572468, 32'h0BADF00D, 4'h0, 8'h0, 32'h0, 64'h0);
    do_vec("post_rst", v);
    prev32 = 32'h13572468; prev64 = 32'h0BADF00D;

    // Randomized aligned transactions against the transaction-level model
    for (int i = 0; i < 120; i++) begin
      int nst;
      logic cancelled;
      v.mw = 1'($urandom_range(0, 1));
      v.op = v.mw ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      v.a  = $urandom & ~(32'(nbytes(v.op)) - 32'd1);
      v.wd = $urandom;
      v.rd = {$urandom, $urandom};
      v.aw = int'($urandom_range(0, 3));
      v.dw = int'($urandom_range(0, 3)) - 1;
      nst  = 1 + (v.aw + 1) + ((v.dw < 0) ? 0 : v.dw + 1);
      v.fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, nst)) : -1;
      cancelled = (v.fl >= 1) && (v.fl <= nst - 1);
      v.st = nst;
      v.rv = cancelled ? 0 : 1;
      if (!v.mw && !cancelled) begin
        prev32 = m_load(4, v.a, v.op, v.rd);
        prev64 = m_load(8, v.a, v.op, v.rd);
      end
      v.ld32 = prev32; v.ld64 = prev64;
      v.ws32 = 4'(m_strobe(4, v.a, v.op)); v.ws64 = m_strobe(8, v.a, v.op);
      v.wd32 = 32'(m_wdata(4, v.wd, v.op)); v.wd64 = m_wdata(8, v.wd, v.op);
      do_vec($sformatf("rnd%0d", i), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
